// File: rtl/fsm_seq_if.sv
// Control bundle between top-level sequencing inputs and the
// load/clear sequencer that drives the datapath register bank.
interface fsm_seq_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
);
  logic                   start;
  logic [CNT_W-1:0]       n_cycles;
  logic                   mode;
  logic                   abort;
  logic                   clr;
  logic [CH-1:0]          ld;
  logic [$clog2(CH)-1:0]  ld_idx;
  logic                   busy;
  logic                   done;

  modport master (
    output start,
    output n_cycles,
    output mode,
    output abort,
    input  clr,
    input  ld,
    input  ld_idx,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  n_cycles,
    input  mode,
    input  abort,
    output clr,
    output ld,
    output ld_idx,
    output busy,
    output done
  );
endinterface

// File: rtl/fsm_seq.sv
// Load/clear sequencer: one clear strobe, N load strobes (round-robin
// or broadcast across CH channels), then a done pulse.
module fsm_seq #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
) (
  input  logic     clk,
  input  logic     reset_n,
  fsm_seq_if.slave bus
);

  localparam int IW = $clog2(CH);
  localparam logic [IW-1:0] PTR_MAX = IW'(CH - 1);
  localparam logic [CH-1:0] ONE_HOT0 = CH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             mode_q, mode_d;
  logic [IW-1:0]    ptr_nxt;

  assign ptr_nxt = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cnt_d   = bus.n_cycles;
          mode_d  = bus.mode;
          ptr_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // cnt is >= 1 whenever LOAD is entered, so this never wraps
        cnt_d = cnt_q - 1'b1;
        if (!mode_q) begin
          idx_d = ptr_q;
          ptr_d = ptr_nxt;
        end
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs depend only on registered state, never on inputs
  always_comb begin
    bus.clr    = 1'b0;
    bus.ld     = '0;
    bus.ld_idx = idx_q;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.busy = 1'b0;
      end
      S_CLEAR: begin
        bus.clr  = 1'b1;
        bus.busy = 1'b1;
      end
      S_LOAD: begin
        bus.busy = 1'b1;
        if (mode_q) begin
          bus.ld = '1;
        end else begin
          bus.ld     = ONE_HOT0 << ptr_q;
          bus.ld_idx = ptr_q;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        bus.busy = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fsm_seq.sv
// Self-checking bench for fsm_seq: directed scenarios plus random
// stimulus against a run-trace reference model.
module tb_fsm_seq;
  localparam int CH    = 4;
  localparam int CNT_W = 8;
  localparam int IW    = $clog2(CH);
  localparam int VW    = CH + IW + 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fsm_seq_if #(.CH(CH), .CNT_W(CNT_W)) bus ();
  fsm_seq #(.CH(CH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    bit            clr;
    bit            done;
    logic [CH-1:0] ld;
    bit            rr;
    int            idx;
  } rec_t;

  // Expected output for each upcoming non-idle cycle; empty = idle
  rec_t exp_q[$];
  int last_idx = 0;
  int errors = 0;
  int checks = 0;

  function automatic logic [VW-1:0] obs();
    return {bus.clr, bus.ld, bus.ld_idx, bus.busy, bus.done};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    rec_t r;
    if (exp_q.size() == 0)
      return {1'b0, {CH{1'b0}}, IW'(last_idx), 1'b0, 1'b0};
    r = exp_q[0];
    return {r.clr, r.ld, IW'(r.rr ? r.idx : last_idx), 1'b1, r.done};
  endfunction

  task automatic push_run(input int n, input bit m);
    rec_t r;
    r = '{clr: 1'b1, done: 1'b0, ld: '0, rr: 1'b0, idx: 0};
    exp_q.push_back(r);
    for (int i = 0; i < n; i++) begin
      r.clr  = 1'b0;
      r.rr   = !m;
      r.idx  = i % CH;
      r.ld   = m ? {CH{1'b1}} : CH'(1) << (i % CH);
      exp_q.push_back(r);
    end
    r = '{clr: 1'b0, done: 1'b1, ld: '0, rr: 1'b0, idx: 0};
    exp_q.push_back(r);
  endtask

  // Drive inputs for the coming edge, advance the model at the edge
  task automatic tick(input bit s, input bit a,
                      input int n, input bit m);
    rec_t r;
    bus.start    = s;
    bus.abort    = a;
    bus.n_cycles = CNT_W'(n);
    bus.mode     = m;
    @(posedge clk);
    if (!reset_n) begin
      exp_q.delete();
      last_idx = 0;
    end else if (exp_q.size() == 0) begin
      if (s) push_run(n, m);
    end else begin
      r = exp_q.pop_front();
      if (r.rr) last_idx = r.idx;
      if (a) exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int nd;
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0);
      checks++;
      if (obs() !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=0", i, obs());
      end
    end
    tick(1, 0, 6, 0);
    tick(0, 0, 6, 0);
    tick(0, 0, 6, 0);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    last_idx = 0;
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=0", obs());
    end
    nd = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 6, 0);
      if (bus.done) nd++;
      checks++;
      if (obs() !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=0", i, obs());
      end
    end
    reset_n = 1'b1;
    tick(0, 0, 0, 0);
    if (bus.done) nd++;
    checks++;
    if (nd !== 0) begin
      errors++;
      $display("FAIL reset_nodone got=%0d exp=0", nd);
    end
  endtask

  task automatic test_broadcast();
    int nb;
    nb = 0;
    tick(1, 0, 3, 1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL bcast cyc=%0d got=%h exp=%h", i, obs(), exp_vec());
      end
      if (bus.ld == 4'b1111) nb++;
      checks++;
      if (bus.ld_idx !== IW'(0)) begin
        errors++;
        $display("FAIL bcast_idx cyc=%0d got=%0d exp=0", i, bus.ld_idx);
      end
      tick(0, 0, 0, 0);
    end
    checks++;
    if (nb !== 3) begin
      errors++;
      $display("FAIL bcast_count got=%0d exp=3", nb);
    end
  endtask

  task automatic test_round_robin();
    int nbusy;
    int ndone;
    logic [CH-1:0] want[6];
    want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    nbusy = 0;
    ndone = 0;
    tick(1, 0, 6, 0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL rr6 cyc=%0d got=%h exp=%h", i, obs(), exp_vec());
      end
      if (i >= 1 && i <= 6) begin
        checks++;
        if (bus.ld !== want[i-1]) begin
          errors++;
          $display("FAIL rr6_ld cyc=%0d got=%b exp=%b",
                   i, bus.ld, want[i-1]);
        end
      end
      if (bus.busy) nbusy++;
      if (bus.done) ndone++;
      tick(0, 0, 6, 0);
    end
    checks++;
    if (nbusy !== 8 || ndone !== 1) begin
      errors++;
      $display("FAIL rr6_busy got=%0d/%0d exp=8/1", nbusy, ndone);
    end
  endtask

  task automatic test_count_bounds();
    int nld;
    nld = 0;
    tick(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL zero cyc=%0d got=%h exp=%h", i, obs(), exp_vec());
      end
      if (bus.ld != '0) nld++;
      tick(0, 0, 0, 0);
    end
    checks++;
    if (nld !== 0) begin
      errors++;
      $display("FAIL zero_ld got=%0d exp=0", nld);
    end
    nld = 0;
    tick(1, 0, 255, 0);
    for (int i = 0; i < 259; i++) begin
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL max cyc=%0d got=%h exp=%h", i, obs(), exp_vec());
      end
      if (bus.ld != '0) nld++;
      tick(0, 0, 0, 0);
    end
    checks++;
    if (nld !== 255) begin
      errors++;
      $display("FAIL max_count got=%0d exp=255", nld);
    end
  endtask

  task automatic test_abort();
    int nld;
    int ndone;
    nld = 0;
    ndone = 0;
    tick(1, 0, 6, 0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL abort cyc=%0d got=%h exp=%h", i, obs(), exp_vec());
      end
      if (bus.ld != '0) nld++;
      if (bus.done) ndone++;
      tick(0, i == 3, 6, 0);
    end
    checks++;
    if (nld !== 3 || ndone !== 0) begin
      errors++;
      $display("FAIL abort_trunc got=%0d/%0d exp=3/0", nld, ndone);
    end
    tick(1, 1, 6, 0);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL restart cyc=%0d got=%h exp=%h",
                 i, obs(), exp_vec());
      end
      if (i == 1) begin
        checks++;
        if (bus.ld !== 4'b0001) begin
          errors++;
          $display("FAIL restart_ch0 got=%b exp=0001", bus.ld);
        end
      end
      tick(0, 0, 0, 0);
    end
  endtask

  task automatic test_back_to_back();
    int prev;
    int nld;
    prev = -1;
    for (int i = 0; i < 21; i++) begin
      tick(1, 0, 2, 0);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h", i, obs(), exp_vec());
      end
      if (bus.clr) begin
        if (prev >= 0) begin
          checks++;
          if (i - prev !== 5) begin
            errors++;
            $display("FAIL b2b_period got=%0d exp=5", i - prev);
          end
        end
        prev = i;
      end
    end
    tick(0, 0, 0, 0);
    while (bus.busy) tick(0, 0, 0, 0);
    nld = 0;
    tick(1, 0, 4, 0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL ignore cyc=%0d got=%h exp=%h", i, obs(), exp_vec());
      end
      if (bus.ld != '0) nld++;
      tick(i == 2, 0, 9, 1);
    end
    checks++;
    if (nld !== 4) begin
      errors++;
      $display("FAIL ignore_count got=%0d exp=4", nld);
    end
  endtask

  task automatic test_random();
    bit s;
    bit a;
    for (int i = 0; i < 600; i++) begin
      s = ($urandom_range(0, 2) == 0);
      a = ($urandom_range(0, 9) == 0);
      tick(s, a, $urandom_range(0, 9), 1'($urandom_range(0, 1)));
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, obs(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.n_cycles = '0;
    bus.mode     = 1'b0;
    test_reset();
    test_broadcast();
    test_round_robin();
    test_count_bounds();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
